// File: rtl/audio_rec_pkg.sv
// Shared types and defaults for the audio recorder SRAM sequencer.
// State codes are visible on o_state and drive the front-panel LEDs.
package audio_rec_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;
    localparam int SRAM_DEPTH = 2 ** DEF_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_REC_WR     = 3'd2,
        ST_REC_PAUSE  = 3'd3,
        ST_PLAY_RD    = 3'd4,
        ST_PLAY_OUT   = 3'd5,
        ST_PLAY_PAUSE = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_STOP  = 3'd1,
        CMD_PAUSE = 3'd2,
        CMD_REC   = 3'd3,
        CMD_PLAY  = 3'd4
    } cmd_t;

endpackage

// File: rtl/rec_cmd_prio.sv
// Resolves the four key pulses into at most one command that is meaningful
// in the current state: starts only from IDLE, stop/pause only outside IDLE.
module rec_cmd_prio
    import audio_rec_pkg::*;
(
    input  state_t state,
    input  logic   rec_start,
    input  logic   play_start,
    input  logic   pause,
    input  logic   stop,
    output cmd_t   cmd
);

    always_comb begin
        cmd = CMD_NONE;
        if (state == ST_IDLE) begin
            if (rec_start)
                cmd = CMD_REC;
            else if (play_start)
                cmd = CMD_PLAY;
        end else begin
            if (stop)
                cmd = CMD_STOP;
            else if (pause)
                cmd = CMD_PAUSE;
        end
    end

endmodule

// File: rtl/audio_rec_ctrl.sv
// Record/playback sequencer owning the single-port sample SRAM; all SRAM pins,
// stream flags and the display address come straight from registers.
module audio_rec_ctrl
    import audio_rec_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rec_start,
    input  logic              i_play_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_rec_valid,
    input  logic [DATA_W-1:0] i_rec_data,
    output logic              o_rec_ready,
    output logic              o_play_valid,
    output logic [DATA_W-1:0] o_play_data,
    input  logic              i_play_ready,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W:0]   o_rec_len,
    output logic [2:0]        o_state
);

    state_t            state;
    cmd_t              cmd;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   rec_len;
    logic              pause_pend;

    // Both streams use valid/ready: a word moves on a cycle where valid and
    // ready are both high at the clock edge; the source holds data and valid
    // stable until then.
    logic rec_hs;
    logic play_hs;
    logic addr_full;
    logic last_word;

    assign rec_hs    = i_rec_valid && o_rec_ready;
    assign play_hs   = o_play_valid && i_play_ready;
    assign addr_full = &addr;
    assign last_word = ({1'b0, addr} == rec_len - (ADDR_W+1)'(1));

    rec_cmd_prio u_cmd (
        .state      (state),
        .rec_start  (i_rec_start),
        .play_start (i_play_start),
        .pause      (i_pause),
        .stop       (i_stop),
        .cmd        (cmd)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            addr         <= '0;
            rec_len      <= '0;
            pause_pend   <= 1'b0;
            o_rec_ready  <= 1'b0;
            o_play_valid <= 1'b0;
            o_play_data  <= '0;
            o_sram_we_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd == CMD_REC) begin
                        state       <= ST_REC;
                        addr        <= '0;
                        rec_len     <= '0;
                        o_rec_ready <= 1'b1;
                    end else if (cmd == CMD_PLAY && rec_len != '0) begin
                        state       <= ST_PLAY_RD;
                        addr        <= '0;
                        o_sram_oe_n <= 1'b0;
                    end
                end
                // A command in the same cycle as a handshake wins; that sample is dropped.
                ST_REC: begin
                    if (cmd == CMD_STOP) begin
                        state       <= ST_IDLE;
                        addr        <= '0;
                        o_rec_ready <= 1'b0;
                    end else if (cmd == CMD_PAUSE) begin
                        state       <= ST_REC_PAUSE;
                        o_rec_ready <= 1'b0;
                    end else if (rec_hs) begin
                        state        <= ST_REC_WR;
                        o_rec_ready  <= 1'b0;
                        o_sram_we_n  <= 1'b0;
                        o_sram_wdata <= i_rec_data;
                    end
                end
                ST_REC_WR: begin
                    o_sram_we_n <= 1'b1;
                    rec_len     <= {1'b0, addr} + (ADDR_W+1)'(1);
                    pause_pend  <= 1'b0;
                    if (addr_full || cmd == CMD_STOP) begin
                        state <= ST_IDLE;
                        addr  <= '0;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                        if (cmd == CMD_PAUSE || pause_pend) begin
                            state <= ST_REC_PAUSE;
                        end else begin
                            state       <= ST_REC;
                            o_rec_ready <= 1'b1;
                        end
                    end
                end
                ST_REC_PAUSE: begin
                    if (cmd == CMD_STOP) begin
                        state <= ST_IDLE;
                        addr  <= '0;
                    end else if (cmd == CMD_PAUSE) begin
                        state       <= ST_REC;
                        o_rec_ready <= 1'b1;
                    end
                end
                ST_PLAY_RD: begin
                    o_sram_oe_n <= 1'b1;
                    if (cmd == CMD_STOP) begin
                        state <= ST_IDLE;
                        addr  <= '0;
                    end else if (cmd == CMD_PAUSE) begin
                        state <= ST_PLAY_PAUSE;
                    end else begin
                        state        <= ST_PLAY_OUT;
                        o_play_data  <= i_sram_rdata;
                        o_play_valid <= 1'b1;
                    end
                end
                // Pause here waits for the handshake so the held word is not lost.
                ST_PLAY_OUT: begin
                    if (cmd == CMD_STOP) begin
                        state        <= ST_IDLE;
                        addr         <= '0;
                        o_play_valid <= 1'b0;
                        pause_pend   <= 1'b0;
                    end else if (play_hs) begin
                        o_play_valid <= 1'b0;
                        pause_pend   <= 1'b0;
                        if (last_word) begin
                            state <= ST_IDLE;
                            addr  <= '0;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                            if (cmd == CMD_PAUSE || pause_pend) begin
                                state <= ST_PLAY_PAUSE;
                            end else begin
                                state       <= ST_PLAY_RD;
                                o_sram_oe_n <= 1'b0;
                            end
                        end
                    end else if (cmd == CMD_PAUSE) begin
                        pause_pend <= 1'b1;
                    end
                end
                ST_PLAY_PAUSE: begin
                    if (cmd == CMD_STOP) begin
                        state <= ST_IDLE;
                        addr  <= '0;
                    end else if (cmd == CMD_PAUSE) begin
                        state       <= ST_PLAY_RD;
                        o_sram_oe_n <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    addr         <= '0;
                    pause_pend   <= 1'b0;
                    o_rec_ready  <= 1'b0;
                    o_play_valid <= 1'b0;
                    o_sram_we_n  <= 1'b1;
                    o_sram_oe_n  <= 1'b1;
                end
            endcase
        end
    end

    assign o_sram_addr = addr;
    assign o_addr      = addr;
    assign o_rec_len   = rec_len;
    assign o_state     = state;

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Bench for audio_rec_ctrl at a 16-word depth so full-memory wrap is reachable;
// an SRAM model, command table, directed sequences and random record/play.
module tb_audio_rec_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_rec_start = 1'b0, i_play_start = 1'b0, i_pause = 1'b0, i_stop = 1'b0;
    logic          i_rec_valid = 1'b0;
    logic [DW-1:0] i_rec_data = '0;
    logic          o_rec_ready, o_play_valid;
    logic [DW-1:0] o_play_data;
    logic          i_play_ready = 1'b0;
    logic [AW-1:0] o_sram_addr, o_addr;
    logic          o_sram_we_n, o_sram_oe_n;
    logic [DW-1:0] o_sram_wdata, i_sram_rdata;
    logic [AW:0]   o_rec_len;
    logic [2:0]    o_state;

    audio_rec_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_rec_start  (i_rec_start),
        .i_play_start (i_play_start),
        .i_pause      (i_pause),
        .i_stop       (i_stop),
        .i_rec_valid  (i_rec_valid),
        .i_rec_data   (i_rec_data),
        .o_rec_ready  (o_rec_ready),
        .o_play_valid (o_play_valid),
        .o_play_data  (o_play_data),
        .i_play_ready (i_play_ready),
        .o_sram_addr  (o_sram_addr),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_oe_n  (o_sram_oe_n),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (i_sram_rdata),
        .o_addr       (o_addr),
        .o_rec_len    (o_rec_len),
        .o_state      (o_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // asynchronous-read SRAM model
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) if (!o_sram_we_n) mem[o_sram_addr] <= o_sram_wdata;
    assign i_sram_rdata = o_sram_oe_n ? '0 : mem[o_sram_addr];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    bit mon_en = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (i_rst_n && o_sram_we_n === 1'b0) begin
            wr_addr_q.push_back(o_sram_addr);
            wr_data_q.push_back(o_sram_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (i_rst_n && o_sram_oe_n === 1'b0) rd_cnt++;
        cyc++;
    end

    // strobes: write low only while writing, read low only while reading
    always @(negedge clk) begin
        if (mon_en && i_rst_n) begin
            check("we_n_vs_state", 32'(o_sram_we_n), 32'(o_state != 3'd2));
            check("oe_n_vs_state", 32'(o_sram_oe_n), 32'(o_state != 3'd4));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        if (o_state != 3'd0) begin
            i_stop = 1'b1;
            tick();
            i_stop = 1'b0;
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(o_state), 0);
        check({tag, "_addr"}, 32'(o_addr), 0);
        check({tag, "_sram_addr"}, 32'(o_sram_addr), 0);
        check({tag, "_rec_len"}, 32'(o_rec_len), 0);
        check({tag, "_rec_ready"}, 32'(o_rec_ready), 0);
        check({tag, "_play_valid"}, 32'(o_play_valid), 0);
        check({tag, "_play_data"}, 32'(o_play_data), 0);
        check({tag, "_we_n"}, 32'(o_sram_we_n), 1);
        check({tag, "_oe_n"}, 32'(o_sram_oe_n), 1);
        check({tag, "_wdata"}, 32'(o_sram_wdata), 0);
    endtask

    task automatic do_record(input int n, input int gap_pct, input bit fixed, output int got);
        int budget;
        bit hs;
        got = 0;
        budget = 0;
        i_rec_start = 1'b1;
        tick();
        i_rec_start = 1'b0;
        while (got < n && budget < 1000) begin
            if (!i_rec_valid && $urandom_range(99) >= gap_pct) begin
                i_rec_valid = 1'b1;
                i_rec_data = fixed ? DW'(16'h1111 * (got + 1)) : DW'($urandom);
            end
            hs = i_rec_valid && o_rec_ready;
            tick();
            budget++;
            if (hs) begin
                exp_q.push_back(i_rec_data);
                got++;
                i_rec_valid = 1'b0;
            end
            if (o_state == 3'd0) break;
        end
        i_rec_valid = 1'b0;
        for (int b = 0; b < 8 && o_state == 3'd2; b++) tick();
    endtask

    task automatic check_writes(input int n);
        check("wr_count", wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check("wr_addr", 32'(wr_addr_q[i]), i);
            check("wr_data", 32'(wr_data_q[i]), 32'(exp_q[i]));
        end
    endtask

    // mode 0: ready toggles every other cycle; mode 1: random ready
    task automatic do_play(input int mode, input int n);
        int k, budget;
        bit hs, stalled;
        logic [DW-1:0] held;
        k = 0;
        budget = 0;
        stalled = 1'b0;
        held = '0;
        i_play_start = 1'b1;
        tick();
        i_play_start = 1'b0;
        while (k < n && budget < 1000) begin
            i_play_ready = (mode == 0) ? budget[0] : 1'($urandom_range(1));
            if (o_play_valid) begin
                if (stalled) check("play_hold", 32'(o_play_data), 32'(held));
                else         check("play_data", 32'(o_play_data), 32'(exp_q[k]));
                held = o_play_data;
            end
            hs = o_play_valid && i_play_ready;
            stalled = o_play_valid && !i_play_ready;
            tick();
            budget++;
            if (hs) begin
                k++;
                if (k < n) begin
                    check("play_next_rd", 32'(o_state), 4);
                    check("play_rd_addr", 32'(o_sram_addr), k);
                end else begin
                    check("play_end_idle", 32'(o_state), 0);
                    check("play_end_addr", 32'(o_addr), 0);
                end
            end
        end
        i_play_ready = 1'b0;
        check("play_count", k, n);
    endtask

    typedef struct {
        int pre;
        bit rec, play, pause, stop;
        int exp_st;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int got;
        int n;

        vecs[0]  = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[2]  = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[4]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[5]  = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[6]  = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[7]  = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[8]  = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        vecs[9]  = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[10] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 3};
        vecs[12] = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[13] = '{3, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vecs[14] = '{3, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        vecs[15] = '{3, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[16] = '{3, 1'b0, 1'b0, 1'b1, 1'b1, 0};

        repeat (3) tick();
        check_reset("reset");
        i_rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // command priority / masking table, rec_len stays 0 throughout
        foreach (vecs[v]) begin
            go_idle();
            if (vecs[v].pre != 0) begin
                i_rec_start = 1'b1; tick(); i_rec_start = 1'b0;
            end
            if (vecs[v].pre == 3) begin
                i_pause = 1'b1; tick(); i_pause = 1'b0;
            end
            i_rec_start  = vecs[v].rec;
            i_play_start = vecs[v].play;
            i_pause      = vecs[v].pause;
            i_stop       = vecs[v].stop;
            tick();
            {i_rec_start, i_play_start, i_pause, i_stop} = 4'b0000;
            check($sformatf("vec%0d_state", v), 32'(o_state), vecs[v].exp_st);
            check($sformatf("vec%0d_ready", v), 32'(o_rec_ready), 32'(vecs[v].exp_st == 1));
        end
        go_idle();
        check("empty_play_no_read", rd_cnt, 0);

        // five fixed samples, valid held high, then stop
        clear_logs();
        do_record(5, 0, 1'b1, got);
        go_idle();
        check("rec5_got", got, 5);
        check_writes(5);
        for (int i = 1; i < wr_cyc_q.size(); i++)
            check("rec5_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], 2);
        check("rec5_len", 32'(o_rec_len), 5);
        check("rec5_addr", 32'(o_addr), 0);
        check("rec5_state", 32'(o_state), 0);

        do_play(0, 5);
        check("play5_len_kept", 32'(o_rec_len), 5);

        // pause during write, resume, stop+pause
        clear_logs();
        i_rec_start = 1'b1; tick(); i_rec_start = 1'b0;
        i_rec_valid = 1'b1; i_rec_data = 16'hA001;
        exp_q.push_back(16'hA001);
        tick();
        check("pw_in_wr", 32'(o_state), 2);
        i_rec_valid = 1'b0; i_pause = 1'b1;
        tick();
        i_pause = 1'b0;
        check("pw_paused", 32'(o_state), 3);
        check("pw_addr", 32'(o_addr), 1);
        check("pw_len", 32'(o_rec_len), 1);
        check("pw_ready", 32'(o_rec_ready), 0);
        repeat (3) tick();
        check("pw_hold", 32'(o_state), 3);
        i_pause = 1'b1; tick(); i_pause = 1'b0;
        check("pw_resume", 32'(o_state), 1);
        i_rec_valid = 1'b1; i_rec_data = 16'hB002;
        exp_q.push_back(16'hB002);
        tick();
        i_rec_valid = 1'b0;
        tick();
        check_writes(2);
        check("pw_len2", 32'(o_rec_len), 2);
        i_pause = 1'b1; i_stop = 1'b1; tick(); i_pause = 1'b0; i_stop = 1'b0;
        check("ps_idle", 32'(o_state), 0);
        check("ps_addr", 32'(o_addr), 0);

        // pause latched while a playback word is waiting
        i_play_start = 1'b1; tick(); i_play_start = 1'b0;
        tick();
        check("pp_out", 32'(o_state), 5);
        check("pp_data_a", 32'(o_play_data), 16'hA001);
        i_pause = 1'b1; tick(); i_pause = 1'b0;
        check("pp_still_out", 32'(o_state), 5);
        check("pp_still_valid", 32'(o_play_valid), 1);
        i_play_ready = 1'b1; tick(); i_play_ready = 1'b0;
        check("pp_paused", 32'(o_state), 6);
        check("pp_addr", 32'(o_addr), 1);
        check("pp_valid_off", 32'(o_play_valid), 0);
        tick();
        check("pp_hold", 32'(o_state), 6);
        i_pause = 1'b1; tick(); i_pause = 1'b0;
        check("pp_reread", 32'(o_state), 4);
        check("pp_reread_addr", 32'(o_sram_addr), 1);
        tick();
        check("pp_data_b", 32'(o_play_data), 16'hB002);
        i_play_ready = 1'b1; tick(); i_play_ready = 1'b0;
        check("pp_done", 32'(o_state), 0);

        // random lengths with gaps, random player ready
        for (int it = 0; it < 3; it++) begin
            clear_logs();
            n = $urandom_range(15, 1);
            do_record(n, 40, 1'b0, got);
            go_idle();
            check("rnd_got", got, n);
            check("rnd_len", 32'(o_rec_len), n);
            check_writes(n);
            do_play(1, n);
        end

        // fill memory: last two addresses written, then IDLE, extra sample refused
        clear_logs();
        do_record(DEPTH + 1, 0, 1'b0, got);
        check("full_got", got, DEPTH);
        check("full_state", 32'(o_state), 0);
        check("full_len", 32'(o_rec_len), DEPTH);
        check_writes(DEPTH);
        i_rec_valid = 1'b1;
        repeat (3) begin
            tick();
            check("full_no_ready", 32'(o_rec_ready), 0);
        end
        i_rec_valid = 1'b0;
        check("full_len_kept", 32'(o_rec_len), DEPTH);
        do_play(1, DEPTH);

        // reset while a playback word is waiting
        i_play_start = 1'b1; tick(); i_play_start = 1'b0;
        tick();
        check("rst_in_out", 32'(o_state), 5);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check_reset("midrst");
        i_play_start = 1'b1; tick(); i_play_start = 1'b0;
        check("midrst_play_ignored", 32'(o_state), 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_rec_ctrl.md
# audio_rec_ctrl

Record/playback sequencer for the lab3 audio recorder: it owns the single-port 1M×16 SRAM and shares it between the recording sample stream and the playback sample stream under key-command control. It generates SRAM address and strobes, tracks recorded length, and exports the live SRAM address that the seven-segment time display decodes (top 5 address bits = seconds). It sits between the I2S recorder/player blocks, the key debouncers and the SRAM pins.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_rec_start, i_play_start, i_pause, i_stop  in  1 each  one-cycle command pulses from debounced keys
- i_rec_valid  in  1  recorder sample valid
- i_rec_data  in  DATA_W  recorder sample
- o_rec_ready  out  1  controller accepts sample this cycle
- o_play_valid  out  1  playback sample valid
- o_play_data  out  DATA_W  playback sample
- i_play_ready  in  1  player consumes sample
- o_sram_addr  out  ADDR_W  SRAM address (registered)
- o_sram_we_n, o_sram_oe_n  out  1 each  SRAM strobes, active-low (registered)
- o_sram_wdata  out  DATA_W  SRAM write data (registered)
- i_sram_rdata  in  DATA_W  SRAM read data
- o_addr  out  ADDR_W  current address, to time display
- o_rec_len  out  ADDR_W+1  words recorded (0..2^ADDR_W)
- o_state  out  3  state code, for LEDs

## Operation
- States: IDLE, REC, REC_WR, REC_PAUSE, PLAY_RD, PLAY_OUT, PLAY_PAUSE.
- Command priority in one cycle: stop > pause > rec_start > play_start; starts ignored outside IDLE; pause in IDLE ignored.
- IDLE: rec_start -> REC, addr=0, rec_len=0. play_start -> PLAY_RD, addr=0, only if rec_len≠0 (else stay IDLE).
- REC: o_rec_ready=1; on valid&&ready register sample, -> REC_WR.
- REC_WR: we_n=0 at addr, wdata=sample, rec_ready=0; rec_len=addr+1; then addr+1 and -> REC, or -> IDLE if addr was 2^ADDR_W−1 (memory full, rec_len=2^ADDR_W).
- PLAY_RD: oe_n=0 at addr; capture i_sram_rdata into o_play_data at cycle end; -> PLAY_OUT.
- PLAY_OUT: o_play_valid=1, data held stable until valid&&ready; then if addr==rec_len−1 -> IDLE, else addr+1, -> PLAY_RD.
- Pause: REC -> REC_PAUSE; PLAY_RD/PLAY_OUT -> PLAY_PAUSE. Pause arriving in REC_WR or PLAY_OUT is latched (pause_pend) and taken after the write completes / after the output handshake. In a pause state, i_pause resumes (REC, or PLAY_RD re-reading addr); starts ignored.
- Stop: from any non-IDLE state -> IDLE, addr=0, valid/ready dropped next cycle; a write in REC_WR completes first (counted in rec_len) and stop is then honoured. rec_len retained after stop.
- o_addr = addr register, returns to 0 on entering IDLE.

## Timing
- Reset (i_rst_n low at posedge): state IDLE, addr 0, rec_len 0, pause_pend 0, o_rec_ready 0, o_play_valid 0, o_play_data 0, o_sram_we_n 1, o_sram_oe_n 1, o_sram_addr 0, o_sram_wdata 0, o_state 0. Reset mid-record discards rec_len.
- Record: handshake cycle n -> SRAM write during n+1 -> o_rec_ready=1 again at n+2, addr incremented. Max 1 sample / 2 cycles.
- Play: PLAY_RD at cycle n (addr/oe_n valid from register), data valid at o_play_valid in n+1; handshake at m -> next PLAY_RD at m+1. Max 1 sample / 2 cycles.
- Only one of we_n/oe_n ever low; both high outside REC_WR/PLAY_RD.
- o_rec_len width ADDR_W+1 to express full memory; addr compare uses rec_len−1 in ADDR_W+1 bits.

## Structure
- Package audio_rec_pkg: state enum (3-bit, codes IDLE=0 … PLAY_PAUSE=6), ADDR_W/DATA_W defaults, SRAM_DEPTH=2**ADDR_W.
- One natural sub-module: rec_cmd_prio — combinational priority/masking of the four command pulses against current state, producing one decoded command.

## Test plan
- Record 5 samples 0x1111..0x5555 with i_rec_valid always high, then stop -> writes at addr 0..4 two cycles apart, rec_len=5, o_addr=0.
- Play after that with i_play_ready toggling every other cycle -> o_play_data 0x1111..0x5555 in order, data stable while ready low, IDLE after fifth handshake.
- play_start with rec_len=0 -> stays IDLE, oe_n never low; rec_start and play_start same cycle -> REC.
- Pause during REC_WR -> write completes, then REC_PAUSE; second pause resumes at next address; stop same cycle as pause -> IDLE.
- Force addr 0xFFFFE, record 3 samples -> writes 0xFFFFE, 0xFFFFF, then IDLE, rec_len=0x100000, third sample not accepted.
- Assert i_rst_n low mid-PLAY_OUT -> next cycle all outputs at reset values, rec_len 0.
